// File: rtl/deserializer.sv
// Packs N_SAMPLES serial words from a val/rdy stream into one parallel frame.
// The frame is then held on a val/rdy output until the consumer takes it.
`timescale 1ns/1ps
module deserializer #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8,
    localparam int unsigned CNT_W    = $clog2(N_SAMPLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0],
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [CNT_W-1:0]     count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BIT_WIDTH-1:0] frame_q [N_SAMPLES-1:0];
    logic [BIT_WIDTH-1:0] frame_d [N_SAMPLES-1:0];
    logic                 recv_xfer;
    logic                 send_xfer;

    assign recv_xfer = (state_q == COLLECT) && recv_val;
    assign send_xfer = (state_q == HOLD) && send_rdy;

    // Next-state, counter and per-slot write enables
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        frame_d = frame_q;
        for (int unsigned i = 0; i < N_SAMPLES; i++) begin
            if (recv_xfer && (count_q == CNT_W'(i))) begin
                frame_d[i] = recv_msg;
            end
        end
        case (state_q)
            COLLECT: begin
                if (recv_xfer) begin
                    if (count_q == LAST_IDX) begin
                        // explicit wrap so non-power-of-two frame sizes work
                        count_d = '0;
                        state_d = HOLD;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (send_xfer) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            count_q <= '0;
            for (int unsigned i = 0; i < N_SAMPLES; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            frame_q <= frame_d;
        end
    end

    // Handshake outputs decode the state register only
    assign recv_rdy = (state_q == COLLECT);
    assign send_val = (state_q == HOLD);
    assign count    = count_q;
    assign send_msg = frame_q;

endmodule
